// File: rtl/vga_bounce_engine.sv
// Bouncing-box pixel generator: moves a square once per frame during vertical
// blanking, cycles its colour on every wall hit and paints an optional border.
module vga_bounce_engine #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int COORD_W   = 10,
    parameter int BOX_SIZE  = 64,
    parameter int SPEED_W   = 4,
    parameter int CBITS     = 4,
    parameter int INIT_X    = 0,
    parameter int INIT_Y    = 0,
    parameter int BORDER_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [SPEED_W-1:0] speed_x,
    input  logic [SPEED_W-1:0] speed_y,
    input  logic               pause,
    output logic [CBITS-1:0]   r,
    output logic [CBITS-1:0]   g,
    output logic [CBITS-1:0]   b,
    output logic               frame_tick,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic [COORD_W-1:0] box_x,
    output logic [COORD_W-1:0] box_y
);

    localparam logic [COORD_W:0]   BOX_W  = (COORD_W+1)'(BOX_SIZE);
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_TICK = COORD_W'(V_ACTIVE);

    // Returns {hit, new_dir, new_pos}; dir 0 = increasing, 1 = decreasing.
    function automatic logic [COORD_W+1:0] step_axis(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [SPEED_W-1:0] spd,
        input logic [COORD_W:0]   max_pos
    );
        logic [COORD_W:0] p;
        logic [COORD_W:0] s;
        logic [COORD_W:0] sum;
        logic [COORD_W:0] diff;
        logic [COORD_W+1:0] res;
        p   = {1'b0, pos};
        s   = '0;
        s[SPEED_W-1:0] = spd;
        sum  = p + s;
        diff = p - s;
        res  = {1'b0, dir, pos};
        if (spd != '0) begin
            if (!dir) begin
                if (sum >= max_pos) res = {1'b1, 1'b1, max_pos[COORD_W-1:0]};
                else                res = {1'b0, 1'b0, sum[COORD_W-1:0]};
            end else begin
                if (p <= s) res = {1'b1, 1'b0, {COORD_W{1'b0}}};
                else        res = {1'b0, 1'b1, diff[COORD_W-1:0]};
            end
        end
        return res;
    endfunction

    logic [COORD_W-1:0] pos_q   [2];
    logic               dir_q   [2];
    logic [SPEED_W-1:0] speed   [2];
    logic [COORD_W:0]   max_pos [2];
    logic [COORD_W+1:0] step_res[2];
    logic [COORD_W-1:0] init_pos[2];

    assign speed[0]    = speed_x;
    assign speed[1]    = speed_y;
    assign max_pos[0]  = (COORD_W+1)'(H_ACTIVE - BOX_SIZE);
    assign max_pos[1]  = (COORD_W+1)'(V_ACTIVE - BOX_SIZE);
    assign init_pos[0] = COORD_W'(INIT_X);
    assign init_pos[1] = COORD_W'(INIT_Y);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            assign step_res[gi] = step_axis(pos_q[gi], dir_q[gi], speed[gi], max_pos[gi]);
        end
    endgenerate

    logic       cond_q, tick_q;
    logic [1:0] bounce_q, bounce_d;
    logic [2:0] idx_q, idx_d;
    logic       update;
    logic [CBITS-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic       tick_cond, in_box, on_border;
    logic [COORD_W:0] x_e, y_e, bx_e, by_e;

    assign tick_cond = (x == '0) && (y == V_TICK);
    assign update    = tick_q && !pause;

    always_comb begin
        bounce_d = 2'b00;
        idx_d    = idx_q;
        if (update) begin
            bounce_d = {step_res[1][COORD_W+1], step_res[0][COORD_W+1]};
            if (bounce_d != 2'b00) idx_d = (idx_q == 3'd7) ? 3'd1 : idx_q + 3'd1;
        end
    end

    // Box overrides border; both are masked outside the active area.
    always_comb begin
        x_e  = {1'b0, x};
        y_e  = {1'b0, y};
        bx_e = {1'b0, pos_q[0]};
        by_e = {1'b0, pos_q[1]};
        in_box = (x_e >= bx_e) && (x_e < bx_e + BOX_W) &&
                 (y_e >= by_e) && (y_e < by_e + BOX_W);
        on_border = (BORDER_EN != 0) &&
                    ((x == '0) || (x == H_LAST) || (y == '0) || (y == V_LAST));
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (video_on) begin
            if (in_box) begin
                r_d = {CBITS{idx_q[2]}};
                g_d = {CBITS{idx_q[1]}};
                b_d = {CBITS{idx_q[0]}};
            end else if (on_border) begin
                r_d = '1;
                g_d = '1;
                b_d = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_q   <= 1'b0;
            tick_q   <= 1'b0;
            bounce_q <= 2'b00;
            idx_q    <= 3'd7;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                pos_q[i] <= init_pos[i];
                dir_q[i] <= 1'b0;
            end
        end else begin
            cond_q   <= tick_cond;
            tick_q   <= tick_cond && !cond_q;
            bounce_q <= bounce_d;
            idx_q    <= idx_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            if (update) begin
                for (int i = 0; i < 2; i++) begin
                    pos_q[i] <= step_res[i][COORD_W-1:0];
                    dir_q[i] <= step_res[i][COORD_W];
                end
            end
        end
    end

    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign frame_tick = tick_q;
    assign bounce_x   = bounce_q[0];
    assign bounce_y   = bounce_q[1];
    assign box_x      = pos_q[0];
    assign box_y      = pos_q[1];

endmodule

// File: tb/tb_vga_bounce_engine.sv
// Randomized bench for vga_bounce_engine against an integer model of the box motion.
module tb_vga_bounce_engine;

    localparam int H = 640, V = 480, CW = 10, BOX = 64, SW = 4, CB = 4;

    logic clk = 1'b0;
    logic reset, video_on, pause;
    logic [CW-1:0] x, y, box_x, box_y;
    logic [SW-1:0] speed_x, speed_y;
    logic [CB-1:0] r, g, b;
    logic frame_tick, bounce_x, bounce_y;

    int total = 0, bad = 0;

    // Reference model state: position, direction (+1/-1), colour index.
    int m_pos[2];
    int m_dir[2];
    int m_idx;
    int m_hit[2];

    always #5 clk = ~clk;

    vga_bounce_engine #(
        .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW), .BOX_SIZE(BOX), .SPEED_W(SW),
        .CBITS(CB), .INIT_X(0), .INIT_Y(0), .BORDER_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
        .speed_x(speed_x), .speed_y(speed_y), .pause(pause),
        .r(r), .g(g), .b(b), .frame_tick(frame_tick),
        .bounce_x(bounce_x), .bounce_y(bounce_y), .box_x(box_x), .box_y(box_y)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pos[0] = 0; m_pos[1] = 0;
        m_dir[0] = 1; m_dir[1] = 1;
        m_idx = 7;
        m_hit[0] = 0; m_hit[1] = 0;
    endtask

    task automatic model_frame(input bit p, input int sx, input int sy);
        int sp, mx;
        m_hit[0] = 0; m_hit[1] = 0;
        if (p) return;
        for (int a = 0; a < 2; a++) begin
            sp = (a == 0) ? sx : sy;
            mx = ((a == 0) ? H : V) - BOX;
            if (sp != 0) begin
                if (m_dir[a] > 0) begin
                    if (m_pos[a] + sp >= mx) begin m_pos[a] = mx; m_dir[a] = -1; m_hit[a] = 1; end
                    else m_pos[a] += sp;
                end else begin
                    if (m_pos[a] <= sp) begin m_pos[a] = 0; m_dir[a] = 1; m_hit[a] = 1; end
                    else m_pos[a] -= sp;
                end
            end
        end
        if (m_hit[0] || m_hit[1]) m_idx = (m_idx == 7) ? 1 : m_idx + 1;
    endtask

    function automatic logic [11:0] exp_pix(input int xx, input int yy, input bit von);
        logic [2:0] ci;
        ci = m_idx[2:0];
        if (!von) return 12'h000;
        if (xx >= m_pos[0] && xx < m_pos[0] + BOX && yy >= m_pos[1] && yy < m_pos[1] + BOX)
            return {{4{ci[2]}}, {4{ci[1]}}, {4{ci[0]}}};
        if (xx == 0 || xx == H - 1 || yy == 0 || yy == V - 1) return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic pix(input int xx, input int yy, input bit von);
        logic [11:0] e;
        x = CW'(xx); y = CW'(yy); video_on = von;
        e = exp_pix(xx, yy, von);
        step();
        check_val($sformatf("pix(%0d,%0d,%0d)", xx, yy, von), {20'd0, r, g, b}, {20'd0, e});
    endtask

    task automatic run_frame(input int npix, input bit p, input int sx, input int sy);
        int xx, yy, hold;
        for (int i = 0; i < npix; i++) begin
            case ($urandom % 4)
                0: begin xx = $urandom_range(0, H - 1); yy = $urandom_range(0, V - 1); end
                1: begin xx = m_pos[0] + $urandom % BOX; yy = m_pos[1] + $urandom % BOX; end
                2: begin xx = ($urandom % 2) ? 0 : H - 1; yy = $urandom_range(0, V - 1); end
                default: begin xx = $urandom_range(0, H - 1); yy = ($urandom % 2) ? 0 : V - 1; end
            endcase
            pix(xx, yy, ($urandom % 6) != 0);
        end
        x = '0; y = CW'(V); video_on = 1'b0;
        speed_x = SW'(sx); speed_y = SW'(sy); pause = p;
        step();
        check_val("tick_hi", {31'd0, frame_tick}, 32'd1);
        hold = $urandom % 3;
        if (hold == 0) x = CW'(1);
        step();
        model_frame(p, sx, sy);
        check_val("tick_lo", {31'd0, frame_tick}, 32'd0);
        check_val("bounce_x", {31'd0, bounce_x}, m_hit[0]);
        check_val("bounce_y", {31'd0, bounce_y}, m_hit[1]);
        check_val("box_x", {22'd0, box_x}, m_pos[0]);
        check_val("box_y", {22'd0, box_y}, m_pos[1]);
        x = CW'(1);
        step();
        check_val("bounce_clr", {30'd0, bounce_x, bounce_y}, 32'd0);
        check_val("tick_once", {31'd0, frame_tick}, 32'd0);
    endtask

    initial begin
        int ticks;
        reset = 1'b1; video_on = 1'b0; x = '0; y = '0;
        speed_x = '0; speed_y = '0; pause = 1'b0;
        model_reset();
        step(); step();
        check_val("rst_box_x", {22'd0, box_x}, 32'd0);
        check_val("rst_box_y", {22'd0, box_y}, 32'd0);
        check_val("rst_rgb", {20'd0, r, g, b}, 32'd0);
        check_val("rst_flags", {29'd0, frame_tick, bounce_x, bounce_y}, 32'd0);
        reset = 1'b0;

        x = CW'(10); y = CW'(10); video_on = 1'b1;
        step();
        check_val("pix_in_box", {20'd0, r, g, b}, 32'hFFF);
        x = CW'(64);
        step();
        check_val("pix_out_box", {20'd0, r, g, b}, 32'h000);

        for (int f = 0; f < 3; f++) run_frame(4, 1'b0, 5, 0);
        check_val("x_after3", {22'd0, box_x}, 32'd15);

        for (int f = 0; f < 43; f++) run_frame(1, 1'b0, 13, 0);
        check_val("x_574", {22'd0, box_x}, 32'd574);
        run_frame(2, 1'b0, 4, 0);
        check_val("x_576", {22'd0, box_x}, 32'd576);
        pix(580, 5, 1'b1);
        check_val("colour1", {20'd0, r, g, b}, 32'h00F);
        run_frame(2, 1'b0, 4, 0);
        check_val("x_572", {22'd0, box_x}, 32'd572);

        ticks = 0;
        for (int f = 0; f < 4; f++) run_frame(3, 1'b1, 7, 7);
        check_val("pause_x", {22'd0, box_x}, 32'd572);
        run_frame(3, 1'b0, 7, 7);

        for (int f = 0; f < 150; f++)
            run_frame(6, ($urandom % 8) == 0, $urandom % 16, $urandom % 16);

        reset = 1'b1; x = CW'(5); y = CW'(200); video_on = 1'b1;
        step();
        model_reset();
        check_val("mid_rst_x", {22'd0, box_x}, 32'd0);
        check_val("mid_rst_y", {22'd0, box_y}, 32'd0);
        check_val("mid_rst_rgb", {20'd0, r, g, b}, 32'd0);
        reset = 1'b0;
        pix(10, 10, 1'b1);

        x = '0; y = CW'(V); video_on = 1'b0; pause = 1'b1;
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) x = CW'(1);
            step();
            ticks += frame_tick;
        end
        check_val("held_x_ticks", ticks, 32'd1);
        pause = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
